// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pkg
// Brief    : Shared load funct3 codes, writeback FSM states and reset polarity.
// Revision : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    localparam logic c_RST_ACTIVE_HIGH = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_if
// Brief    : MEM-to-WB retire handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
);
    logic                   mem_valid;
    logic                   wb_ready;
    logic                   flush;
    logic [RADDR_WIDTH-1:0] mem_rd_addr;
    logic                   mem_rd_wen;
    logic                   mem_is_load;
    logic [2:0]             mem_funct3;
    logic [DATA_WIDTH-1:0]  mem_result;

    modport master (
        output mem_valid, flush, mem_rd_addr, mem_rd_wen,
               mem_is_load, mem_funct3, mem_result,
        input  wb_ready
    );

    modport slave (
        input  mem_valid, flush, mem_rd_addr, mem_rd_wen,
               mem_is_load, mem_funct3, mem_result,
        output wb_ready
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_load_align
// Brief    : Selects and extends load data; flags misaligned/illegal loads.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [2:0]            i_funct3,
    input  wire logic [1:0]            i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_rdata,
    output logic      [DATA_WIDTH-1:0] o_data,
    output logic                       o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data = '0;
        o_err  = 1'b0;
        case (i_funct3)
            c_F3_LB:  o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            c_F3_LBU: o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            c_F3_LH: begin
                o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
                o_err  = i_addr[0];
            end
            c_F3_LHU: begin
                o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
                o_err  = i_addr[0];
            end
            c_F3_LW: begin
                o_data = i_rdata;
                o_err  = |i_addr;
            end
            default:  o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : rv32i writeback stage: load wait, alignment, regfile write, instret.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    wb_stage_if.slave                   mem,
    input  wire logic                   dmem_rvalid,
    input  wire logic [DATA_WIDTH-1:0]  dmem_rdata,
    output logic      [RADDR_WIDTH-1:0] waddr,
    output logic      [DATA_WIDTH-1:0]  wdata,
    output logic                        wen,
    output logic                        load_err,
    output logic      [CNT_WIDTH-1:0]   instret
);

    wb_state_t              r_state;
    logic [RADDR_WIDTH-1:0] r_ld_rd;
    logic                   r_ld_wen;
    logic [2:0]             r_ld_f3;
    logic [1:0]             r_ld_addr;

    // One-entry slot for a result that collides with a load response on the write port
    logic                   r_pend_vld;
    logic                   r_pend_err;
    logic                   r_pend_wen;
    logic [RADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0]  r_pend_data;

    logic                   w_ready;
    logic                   w_rsp_fire;
    logic                   w_capture;
    logic                   w_cap_align_err;
    logic                   w_cap_imm;
    logic                   w_cap_ld;
    logic                   w_cap_err;
    logic                   w_cap_wen;
    logic [DATA_WIDTH-1:0]  w_rsp_data;
    logic [DATA_WIDTH-1:0]  w_cap_data_unused;
    logic                   w_rsp_err_unused;
    logic [1:0]             w_retire;

    logic                   w_emit_vld;
    logic                   w_emit_err;
    logic                   w_emit_wen;
    logic [RADDR_WIDTH-1:0] w_emit_addr;
    logic [DATA_WIDTH-1:0]  w_emit_data;

    assign w_rsp_fire   = (r_state == ST_WAIT) && dmem_rvalid;
    assign w_ready      = (r_state == ST_IDLE) || w_rsp_fire;
    assign mem.wb_ready = w_ready;

    assign w_capture = mem.mem_valid && w_ready && !mem.flush;
    assign w_cap_imm = w_capture && (!mem.mem_is_load || w_cap_align_err);
    assign w_cap_ld  = w_capture && mem.mem_is_load && !w_cap_align_err;
    assign w_cap_err = mem.mem_is_load;
    assign w_cap_wen = !mem.mem_is_load && mem.mem_rd_wen && (mem.mem_rd_addr != '0);
    assign w_retire  = {1'b0, w_rsp_fire} + {1'b0, w_capture && !mem.mem_is_load};

    wb_stage_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_cap_align (
        .i_funct3 (mem.mem_funct3),
        .i_addr   (mem.mem_result[1:0]),
        .i_rdata  ('0),
        .o_data   (w_cap_data_unused),
        .o_err    (w_cap_align_err)
    );

    wb_stage_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_align (
        .i_funct3 (r_ld_f3),
        .i_addr   (r_ld_addr),
        .i_rdata  (dmem_rdata),
        .o_data   (w_rsp_data),
        .o_err    (w_rsp_err_unused)
    );

    // Oldest result owns the write port: pending slot, then load response, then capture
    always_comb begin
        w_emit_vld  = 1'b0;
        w_emit_err  = 1'b0;
        w_emit_wen  = 1'b0;
        w_emit_addr = '0;
        w_emit_data = '0;
        if (r_pend_vld) begin
            w_emit_vld  = 1'b1;
            w_emit_err  = r_pend_err;
            w_emit_wen  = r_pend_wen;
            w_emit_addr = r_pend_addr;
            w_emit_data = r_pend_data;
        end else if (w_rsp_fire) begin
            w_emit_vld  = 1'b1;
            w_emit_wen  = r_ld_wen && (r_ld_rd != '0);
            w_emit_addr = r_ld_rd;
            w_emit_data = w_rsp_data;
        end else if (w_cap_imm) begin
            w_emit_vld  = 1'b1;
            w_emit_err  = w_cap_err;
            w_emit_wen  = w_cap_wen;
            w_emit_addr = mem.mem_rd_addr;
            w_emit_data = mem.mem_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == c_RST_ACTIVE_HIGH) begin
            r_state     <= ST_IDLE;
            r_ld_rd     <= '0;
            r_ld_wen    <= 1'b0;
            r_ld_f3     <= '0;
            r_ld_addr   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_err  <= 1'b0;
            r_pend_wen  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            waddr       <= '0;
            wdata       <= '0;
            wen         <= 1'b0;
            load_err    <= 1'b0;
            instret     <= '0;
        end else begin
            wen      <= w_emit_vld && !w_emit_err && w_emit_wen;
            load_err <= w_emit_vld && w_emit_err;
            if (w_emit_vld && !w_emit_err && w_emit_wen) begin
                waddr <= w_emit_addr;
                wdata <= w_emit_data;
            end
            instret <= instret + CNT_WIDTH'(w_retire);

            r_pend_vld <= w_cap_imm && (r_pend_vld || w_rsp_fire);
            if (w_cap_imm) begin
                r_pend_err  <= w_cap_err;
                r_pend_wen  <= w_cap_wen;
                r_pend_addr <= mem.mem_rd_addr;
                r_pend_data <= mem.mem_result;
            end

            if (w_cap_ld) begin
                r_state   <= ST_WAIT;
                r_ld_rd   <= mem.mem_rd_addr;
                r_ld_wen  <= mem.mem_rd_wen;
                r_ld_f3   <= mem.mem_funct3;
                r_ld_addr <= mem.mem_result[1:0];
            end else if (w_rsp_fire) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule
`default_nettype wire
